// File: rtl/tanh_share_sched.sv
// ---------------------------------------------------------------------------
// tanh_share_sched
// Round-robin scheduler that shares one tanh activation unit between N
// neuron requesters. The z value of the winning requester is registered onto
// fn_z. A tag pipeline, matched to the unit latency, records which requester
// owns each in-flight value, so every returned activation is delivered on a
// common result bus together with its requester id.
//
// Parameters
//   N    number of requesters (2..16)
//   W    data width of z and a (signed, passed through unmodified)
//   LAT  latency of the shared unit in cycles, fn_z -> fn_a (0 = combinational)
//   IDW  requester id width
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  [N]    per-requester request valid
//   req_z      [N*W]  packed z values, requester i in [i*W +: W]
//   req_ready  [N]    one-hot grant (combinational, 0 while rst)
//   fn_z       [W]    registered z driven to the shared unit
//   fn_a       [W]    activation returned by the shared unit
//   res_valid  1      one-cycle pulse per delivered result
//   res_id     [IDW]  requester that owns res_a
//   res_a      [W]    registered activation
//   inflight   [CW]   issued requests whose result has not been delivered
// ---------------------------------------------------------------------------
module tanh_share_sched #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int LAT = 0,
    parameter int IDW = $clog2(N),
    localparam int CW = $clog2(LAT + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_z,
    output logic [N-1:0]     req_ready,
    output logic [W-1:0]     fn_z,
    input  logic [W-1:0]     fn_a,
    output logic             res_valid,
    output logic [IDW-1:0]   res_id,
    output logic [W-1:0]     res_a,
    output logic [CW-1:0]    inflight
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] grant_id;
    logic           found;
    logic           issue;
    int             idx;

    // Tag stage j holds the owner of the value issued j edges ago; the last
    // stage lines up with the edge at which fn_a belongs to that value.
    logic [LAT:0]   tag_valid;
    logic [IDW-1:0] tag_id [0:LAT];

    // Rotating priority search starting at ptr. Depends only on req_valid,
    // never on req_z.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                grant_id = IDW'(idx);
            end
        end
    end

    assign issue = found && !rst;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            fn_z      <= '0;
            tag_valid <= '0;
            for (int j = 0; j <= LAT; j++) begin
                tag_id[j] <= '0;
            end
            res_valid <= 1'b0;
            res_id    <= '0;
            res_a     <= '0;
        end else begin
            if (issue) begin
                fn_z <= req_z[int'(grant_id)*W +: W];
                ptr  <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
            end
            tag_valid[0] <= issue;
            tag_id[0]    <= grant_id;
            for (int j = 1; j <= LAT; j++) begin
                tag_valid[j] <= tag_valid[j-1];
                tag_id[j]    <= tag_id[j-1];
            end
            res_valid <= tag_valid[LAT];
            if (tag_valid[LAT]) begin
                res_a  <= fn_a;
                res_id <= tag_id[LAT];
            end
        end
    end

    // Every valid tag stage is one issued request not yet delivered.
    always_comb begin
        inflight = '0;
        for (int j = 0; j <= LAT; j++) begin
            inflight = inflight + CW'(tag_valid[j]);
        end
    end

endmodule
